// File: rtl/fire_ctrl_if.sv
// Bundles the acquisition sample stream and the launcher request/acknowledge pair
// that fire_ctrl consumes and drives.
interface fire_ctrl_if;
  // Sample stream: a sample transfers on a clock edge where data_in_valid and
  // data_in_ready are both 1; x_in/y_in/target_found_in are only meaningful while
  // data_in_valid is 1. Launcher side: fire_req stays high with fire_x/fire_y
  // frozen until the edge that samples fire_ack=1.
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        target_found_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic        fire_req;
  logic [15:0] fire_x;
  logic [15:0] fire_y;
  logic        fire_ack;

  modport master (
    output x_in, y_in, target_found_in, data_in_valid, fire_ack,
    input  data_in_ready, fire_req, fire_x, fire_y
  );

  modport slave (
    input  x_in, y_in, target_found_in, data_in_valid, fire_ack,
    output data_in_ready, fire_req, fire_x, fire_y
  );
endinterface

// File: rtl/fire_ctrl.sv
// Engagement controller: confirms a stable in-zone lock, waits for arm release,
// issues a held fire request with latched coordinates, then cools down.
module fire_ctrl #(
  parameter logic [15:0] ZONE_X_MIN      = 16'd100,
  parameter logic [15:0] ZONE_X_MAX      = 16'd60000,
  parameter logic [15:0] ZONE_Y_MIN      = 16'd100,
  parameter logic [15:0] ZONE_Y_MAX      = 16'd60000,
  parameter int unsigned CONFIRM_COUNT   = 3,
  parameter logic [15:0] ARM_TIMEOUT     = 16'd1000,
  parameter logic [15:0] COOLDOWN_CYCLES = 16'd500
) (
  input  logic              clk,
  input  logic              reset,
  fire_ctrl_if.slave        bus,
  input  logic              arm_enable,
  output logic              abort,
  output logic [2:0]        state_out,
  output logic [7:0]        engage_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TRACK    = 3'd1,
    ST_ARMED    = 3'd2,
    ST_FIRE     = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  localparam logic [3:0]  CONFIRM_TGT  = 4'(CONFIRM_COUNT);
  localparam logic [15:0] ARM_LAST     = ARM_TIMEOUT - 16'd1;
  localparam logic [15:0] COOLDOWN_LAST = COOLDOWN_CYCLES - 16'd1;

  state_t      state_q, state_d;
  logic [3:0]  confirm_q, confirm_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] coord_x_q, coord_x_d;
  logic [15:0] coord_y_q, coord_y_d;
  logic        fire_req_q, fire_req_d;
  logic        abort_q, abort_d;
  logic [7:0]  engage_q, engage_d;

  logic accept;
  logic qualify;
  logic in_zone;

  assign bus.data_in_ready = (state_q != ST_FIRE);
  assign accept  = bus.data_in_valid && bus.data_in_ready;
  assign in_zone = (bus.x_in >= ZONE_X_MIN) && (bus.x_in <= ZONE_X_MAX) &&
                   (bus.y_in >= ZONE_Y_MIN) && (bus.y_in <= ZONE_Y_MAX);
  assign qualify = bus.target_found_in && in_zone;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      confirm_q  <= 4'd0;
      timer_q    <= 16'd0;
      coord_x_q  <= 16'd0;
      coord_y_q  <= 16'd0;
      fire_req_q <= 1'b0;
      abort_q    <= 1'b0;
      engage_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      confirm_q  <= confirm_d;
      timer_q    <= timer_d;
      coord_x_q  <= coord_x_d;
      coord_y_q  <= coord_y_d;
      fire_req_q <= fire_req_d;
      abort_q    <= abort_d;
      engage_q   <= engage_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    confirm_d  = confirm_q;
    timer_d    = timer_q;
    coord_x_d  = coord_x_q;
    coord_y_d  = coord_y_q;
    fire_req_d = fire_req_q;
    abort_d    = 1'b0;
    engage_d   = engage_q;

    // The coordinate register tracks the newest qualifying sample until FIRE freezes it.
    if (accept && qualify &&
        (state_q == ST_IDLE || state_q == ST_TRACK || state_q == ST_ARMED)) begin
      coord_x_d = bus.x_in;
      coord_y_d = bus.y_in;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && qualify) begin
          confirm_d = 4'd1;
          if (CONFIRM_TGT == 4'd1) begin
            state_d = ST_ARMED;
            timer_d = 16'd0;
          end else begin
            state_d = ST_TRACK;
          end
        end
      end

      ST_TRACK: begin
        if (accept) begin
          if (qualify) begin
            confirm_d = confirm_q + 4'd1;
            if (confirm_q + 4'd1 == CONFIRM_TGT) begin
              state_d = ST_ARMED;
              timer_d = 16'd0;
            end
          end else begin
            state_d   = ST_IDLE;
            confirm_d = 4'd0;
          end
        end
      end

      // Lock loss outranks timeout, which outranks the operator release.
      ST_ARMED: begin
        timer_d = timer_q + 16'd1;
        if (accept && !qualify) begin
          state_d   = ST_IDLE;
          confirm_d = 4'd0;
          abort_d   = 1'b1;
        end else if (timer_q == ARM_LAST) begin
          state_d   = ST_IDLE;
          confirm_d = 4'd0;
          abort_d   = 1'b1;
        end else if (arm_enable) begin
          state_d    = ST_FIRE;
          fire_req_d = 1'b1;
        end
      end

      ST_FIRE: begin
        if (bus.fire_ack) begin
          state_d    = ST_COOLDOWN;
          fire_req_d = 1'b0;
          timer_d    = 16'd0;
          if (engage_q != 8'hFF) begin
            engage_d = engage_q + 8'd1;
          end
        end
      end

      ST_COOLDOWN: begin
        if (timer_q == COOLDOWN_LAST) begin
          state_d   = ST_IDLE;
          confirm_d = 4'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        confirm_d  = 4'd0;
        fire_req_d = 1'b0;
      end
    endcase
  end

  assign bus.fire_req  = fire_req_q;
  assign bus.fire_x    = coord_x_q;
  assign bus.fire_y    = coord_y_q;
  assign abort         = abort_q;
  assign state_out     = state_q;
  assign engage_count  = engage_q;

  a_req_matches_state: assert property (@(posedge clk) disable iff (reset)
    fire_req_q == (state_q == ST_FIRE));

  a_coords_frozen: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_FIRE) |=> (state_q != ST_FIRE) || ($stable(coord_x_q) && $stable(coord_y_q)));

  a_abort_single: assert property (@(posedge clk) disable iff (reset)
    abort_q |=> !abort_q);

endmodule

// File: tb/tb_fire_ctrl.sv
// Directed bench for fire_ctrl: a default build plus a CONFIRM_COUNT=1 build with
// short timers used for the single-sample arm path and counter saturation.
module tb_fire_ctrl;

  logic       clk;
  logic       reset;
  logic       arm0, arm1;
  logic       abort0, abort1;
  logic [2:0] st0, st1;
  logic [7:0] eng0, eng1;
  int         total;
  int         bad;

  fire_ctrl_if if0 ();
  fire_ctrl_if if1 ();

  fire_ctrl dut0 (
    .clk          (clk),
    .reset        (reset),
    .bus          (if0),
    .arm_enable   (arm0),
    .abort        (abort0),
    .state_out    (st0),
    .engage_count (eng0)
  );

  fire_ctrl #(
    .CONFIRM_COUNT   (1),
    .ARM_TIMEOUT     (16'd50),
    .COOLDOWN_CYCLES (16'd4)
  ) dut1 (
    .clk          (clk),
    .reset        (reset),
    .bus          (if1),
    .arm_enable   (arm1),
    .abort        (abort1),
    .state_out    (st1),
    .engage_count (eng1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [15:0] x, input logic [15:0] y, input logic f);
    if0.x_in = x; if0.y_in = y; if0.target_found_in = f; if0.data_in_valid = 1'b1;
    tick();
    if0.data_in_valid = 1'b0;
  endtask

  task automatic send1(input logic [15:0] x, input logic [15:0] y, input logic f);
    if1.x_in = x; if1.y_in = y; if1.target_found_in = f; if1.data_in_valid = 1'b1;
    tick();
    if1.data_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (st0 !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", st0); end
    total++; if (if0.fire_req !== 1'b0) begin bad++; $display("FAIL reset_fire_req: got %0b want 0", if0.fire_req); end
    total++; if (if0.fire_x !== 16'd0 || if0.fire_y !== 16'd0) begin bad++; $display("FAIL reset_coords: got %0d,%0d want 0,0", if0.fire_x, if0.fire_y); end
    total++; if (abort0 !== 1'b0) begin bad++; $display("FAIL reset_abort: got %0b want 0", abort0); end
    total++; if (eng0 !== 8'd0) begin bad++; $display("FAIL reset_engage: got %0d want 0", eng0); end
    total++; if (if0.data_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", if0.data_in_ready); end
    total++; if (st1 !== 3'd0) begin bad++; $display("FAIL reset_state1: got %0d want 0", st1); end
  endtask

  task automatic test_basic_fire;
    arm0 = 1'b1;
    send0(16'd500, 16'd600, 1'b1);
    total++; if (st0 !== 3'd1) begin bad++; $display("FAIL first_sample_track: got %0d want 1", st0); end
    send0(16'd500, 16'd600, 1'b1);
    total++; if (st0 !== 3'd1) begin bad++; $display("FAIL second_sample_track: got %0d want 1", st0); end
    send0(16'd500, 16'd600, 1'b1);
    total++; if (st0 !== 3'd2) begin bad++; $display("FAIL third_sample_armed: got %0d want 2", st0); end
    tick();
    total++; if (st0 !== 3'd3) begin bad++; $display("FAIL fire_state: got %0d want 3", st0); end
    total++; if (if0.fire_req !== 1'b1) begin bad++; $display("FAIL fire_req_rise: got %0b want 1", if0.fire_req); end
    total++; if (if0.fire_x !== 16'd500 || if0.fire_y !== 16'd600) begin bad++; $display("FAIL fire_coords: got %0d,%0d want 500,600", if0.fire_x, if0.fire_y); end
    total++; if (if0.data_in_ready !== 1'b0) begin bad++; $display("FAIL fire_ready_low: got %0b want 0", if0.data_in_ready); end
    send0(16'd1234, 16'd4321, 1'b1);
    total++; if (if0.fire_x !== 16'd500 || st0 !== 3'd3) begin bad++; $display("FAIL fire_frozen: got x=%0d st=%0d want x=500 st=3", if0.fire_x, st0); end
  endtask

  task automatic test_ack_cooldown;
    int n;
    arm0 = 1'b0;
    if0.fire_ack = 1'b1;
    tick();
    if0.fire_ack = 1'b0;
    total++; if (st0 !== 3'd4) begin bad++; $display("FAIL ack_cooldown_state: got %0d want 4", st0); end
    total++; if (if0.fire_req !== 1'b0) begin bad++; $display("FAIL ack_req_drop: got %0b want 0", if0.fire_req); end
    total++; if (eng0 !== 8'd1) begin bad++; $display("FAIL ack_engage: got %0d want 1", eng0); end
    total++; if (if0.data_in_ready !== 1'b1) begin bad++; $display("FAIL cooldown_ready: got %0b want 1", if0.data_in_ready); end
    if0.x_in = 16'd700; if0.y_in = 16'd800; if0.target_found_in = 1'b1; if0.data_in_valid = 1'b1;
    n = 0;
    while (st0 == 3'd4 && n < 600) begin
      n++;
      tick();
    end
    if0.data_in_valid = 1'b0;
    total++; if (n !== 500) begin bad++; $display("FAIL cooldown_len: got %0d want 500", n); end
    total++; if (st0 !== 3'd0) begin bad++; $display("FAIL cooldown_exit: got %0d want 0", st0); end
    total++; if (if0.fire_x !== 16'd500) begin bad++; $display("FAIL cooldown_no_latch: got %0d want 500", if0.fire_x); end
    send0(16'd700, 16'd800, 1'b1);
    total++; if (st0 !== 3'd1) begin bad++; $display("FAIL post_cooldown_track: got %0d want 1", st0); end
    send0(16'd700, 16'd800, 1'b1);
    total++; if (st0 !== 3'd1) begin bad++; $display("FAIL post_cooldown_confirm2: got %0d want 1", st0); end
  endtask

  task automatic test_track_drop;
    send0(16'd50, 16'd800, 1'b1);
    total++; if (st0 !== 3'd0) begin bad++; $display("FAIL drop_idle: got %0d want 0", st0); end
    total++; if (abort0 !== 1'b0) begin bad++; $display("FAIL drop_no_abort: got %0b want 0", abort0); end
    total++; if (if0.fire_x !== 16'd700) begin bad++; $display("FAIL drop_no_latch: got %0d want 700", if0.fire_x); end
    send0(16'd900, 16'd900, 1'b1);
    send0(16'd900, 16'd900, 1'b1);
    total++; if (st0 !== 3'd1) begin bad++; $display("FAIL drop_reconfirm2: got %0d want 1", st0); end
    send0(16'd900, 16'd900, 1'b1);
    total++; if (st0 !== 3'd2) begin bad++; $display("FAIL drop_rearm: got %0d want 2", st0); end
  endtask

  task automatic test_arm_timeout;
    int n;
    int ab;
    n = 0; ab = 0;
    while (st0 == 3'd2 && n < 1100) begin
      n++;
      if (abort0) ab++;
      tick();
    end
    total++; if (n !== 1000) begin bad++; $display("FAIL timeout_len: got %0d want 1000", n); end
    total++; if (st0 !== 3'd0 || abort0 !== 1'b1) begin bad++; $display("FAIL timeout_abort: got st=%0d abort=%0b want 0,1", st0, abort0); end
    total++; if (ab !== 0) begin bad++; $display("FAIL timeout_early_abort: got %0d want 0", ab); end
    tick();
    total++; if (abort0 !== 1'b0) begin bad++; $display("FAIL timeout_pulse_width: got %0b want 0", abort0); end
    send0(16'd900, 16'd900, 1'b1);
    send0(16'd900, 16'd900, 1'b1);
    send0(16'd900, 16'd900, 1'b1);
    total++; if (st0 !== 3'd2) begin bad++; $display("FAIL abort_win_armed: got %0d want 2", st0); end
    arm0 = 1'b1;
    send0(16'd500, 16'd600, 1'b0);
    total++; if (st0 !== 3'd0 || abort0 !== 1'b1 || if0.fire_req !== 1'b0) begin bad++; $display("FAIL abort_wins: got st=%0d abort=%0b req=%0b want 0,1,0", st0, abort0, if0.fire_req); end
    tick();
    total++; if (st0 !== 3'd0 || abort0 !== 1'b0 || if0.fire_req !== 1'b0) begin bad++; $display("FAIL abort_wins_after: got st=%0d abort=%0b req=%0b want 0,0,0", st0, abort0, if0.fire_req); end
    arm0 = 1'b0;
  endtask

  task automatic test_boundary;
    send0(16'd60001, 16'd500, 1'b1);
    total++; if (st0 !== 3'd0) begin bad++; $display("FAIL idle_ignore_oob: got %0d want 0", st0); end
    send0(16'd100, 16'd60000, 1'b1);
    total++; if (st0 !== 3'd1 || if0.fire_x !== 16'd100 || if0.fire_y !== 16'd60000) begin bad++; $display("FAIL edge_min_max: got st=%0d %0d,%0d want 1 100,60000", st0, if0.fire_x, if0.fire_y); end
    send0(16'd99, 16'd500, 1'b1);
    total++; if (st0 !== 3'd0 || if0.fire_x !== 16'd100) begin bad++; $display("FAIL x_99_rejected: got st=%0d x=%0d want 0 100", st0, if0.fire_x); end
    send0(16'd60000, 16'd100, 1'b1);
    total++; if (st0 !== 3'd1 || if0.fire_x !== 16'd60000 || if0.fire_y !== 16'd100) begin bad++; $display("FAIL edge_max_min: got st=%0d %0d,%0d want 1 60000,100", st0, if0.fire_x, if0.fire_y); end
    send0(16'd500, 16'd60001, 1'b1);
    total++; if (st0 !== 3'd0) begin bad++; $display("FAIL y_60001_rejected: got %0d want 0", st0); end
    send0(16'd500, 16'd500, 1'b1);
    send0(16'd500, 16'd500, 1'b0);
    total++; if (st0 !== 3'd0) begin bad++; $display("FAIL not_found_rejected: got %0d want 0", st0); end
    if0.fire_ack = 1'b1;
    tick();
    if0.fire_ack = 1'b0;
    total++; if (st0 !== 3'd0 || eng0 !== 8'd1 || if0.fire_req !== 1'b0) begin bad++; $display("FAIL stray_ack: got st=%0d eng=%0d req=%0b want 0,1,0", st0, eng0, if0.fire_req); end
  endtask

  task automatic test_confirm_one;
    int n;
    send1(16'd700, 16'd800, 1'b1);
    total++; if (st1 !== 3'd2) begin bad++; $display("FAIL c1_direct_armed: got %0d want 2", st1); end
    arm1 = 1'b1;
    tick();
    total++; if (st1 !== 3'd3 || if1.fire_req !== 1'b1) begin bad++; $display("FAIL c1_fire: got st=%0d req=%0b want 3,1", st1, if1.fire_req); end
    total++; if (if1.fire_x !== 16'd700 || if1.fire_y !== 16'd800) begin bad++; $display("FAIL c1_coords: got %0d,%0d want 700,800", if1.fire_x, if1.fire_y); end
    if1.fire_ack = 1'b1;
    tick();
    if1.fire_ack = 1'b0;
    total++; if (st1 !== 3'd4 || eng1 !== 8'd1) begin bad++; $display("FAIL c1_ack: got st=%0d eng=%0d want 4,1", st1, eng1); end
    n = 0;
    while (st1 != 3'd0 && n < 20) begin
      n++;
      tick();
    end
    total++; if (n !== 4) begin bad++; $display("FAIL c1_cooldown_len: got %0d want 4", n); end
  endtask

  task automatic test_saturation;
    int n;
    int fire_ok;
    fire_ok = 0;
    for (int i = 0; i < 255; i++) begin
      send1(16'(1000 + i), 16'd2000, 1'b1);
      tick();
      if (st1 == 3'd3 && if1.fire_req == 1'b1) fire_ok++;
      if1.fire_ack = 1'b1;
      tick();
      if1.fire_ack = 1'b0;
      if (i == 253) begin
        total++; if (eng1 !== 8'd255) begin bad++; $display("FAIL engage_255: got %0d want 255", eng1); end
      end
      n = 0;
      while (st1 != 3'd0 && n < 20) begin
        n++;
        tick();
      end
    end
    total++; if (fire_ok !== 255) begin bad++; $display("FAIL sat_shots_fired: got %0d want 255", fire_ok); end
    total++; if (eng1 !== 8'd255) begin bad++; $display("FAIL engage_saturated: got %0d want 255", eng1); end
  endtask

  task automatic test_reset_in_fire;
    send1(16'd3000, 16'd4000, 1'b1);
    tick();
    total++; if (if1.fire_req !== 1'b1) begin bad++; $display("FAIL rst_pre_fire: got %0b want 1", if1.fire_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    arm1 = 1'b0;
    total++; if (if1.fire_req !== 1'b0 || st1 !== 3'd0) begin bad++; $display("FAIL rst_in_fire: got req=%0b st=%0d want 0,0", if1.fire_req, st1); end
    total++; if (eng1 !== 8'd0 || if1.fire_x !== 16'd0 || abort1 !== 1'b0) begin bad++; $display("FAIL rst_clears: got eng=%0d x=%0d abort=%0b want 0,0,0", eng1, if1.fire_x, abort1); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; arm0 = 1'b0; arm1 = 1'b0;
    if0.x_in = '0; if0.y_in = '0; if0.target_found_in = 1'b0; if0.data_in_valid = 1'b0; if0.fire_ack = 1'b0;
    if1.x_in = '0; if1.y_in = '0; if1.target_found_in = 1'b0; if1.data_in_valid = 1'b0; if1.fire_ack = 1'b0;
    test_reset();
    test_basic_fire();
    test_ack_cooldown();
    test_track_drop();
    test_arm_timeout();
    test_boundary();
    test_confirm_one();
    test_saturation();
    test_reset_in_fire();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fire_ctrl.md
Name: fire_ctrl

Overview:
- Downstream consumer of the target acquisition stage's output stream: x, y, target_found with valid/ready.
- Confirms a stable, in-zone lock over consecutive samples, then waits for operator arm.
- Issues a held fire request with latched coordinates to the launcher and waits for acknowledge.
- Enforces a cooldown before re-engaging.

Parameters:
ZONE_X_MIN, 16'd100, inclusive lower X bound of engagement zone (unsigned)
ZONE_X_MAX, 16'd60000, inclusive upper X bound
ZONE_Y_MIN, 16'd100, inclusive lower Y bound
ZONE_Y_MAX, 16'd60000, inclusive upper Y bound
CONFIRM_COUNT, 3, consecutive qualifying samples required to arm (1..15)
ARM_TIMEOUT, 16'd1000, cycles allowed in ARMED without arm_enable before abort
COOLDOWN_CYCLES, 16'd500, cycles spent in COOLDOWN after an acknowledged shot

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
x_in  in  16  target X from acquisition stage
y_in  in  16  target Y from acquisition stage
target_found_in  in  1  lock flag accompanying sample
data_in_valid  in  1  upstream sample valid
data_in_ready  out  1  block accepts sample
arm_enable  in  1  operator/system release (level)
fire_req  out  1  fire request, held until acknowledged
fire_x  out  16  latched X for launcher, stable while fire_req
fire_y  out  16  latched Y for launcher, stable while fire_req
fire_ack  in  1  launcher acknowledge
abort  out  1  one-cycle pulse on lock loss or arm timeout
state_out  out  3  IDLE=0, TRACK=1, ARMED=2, FIRE=3, COOLDOWN=4
engage_count  out  8  acknowledged shots, saturates at 255

Behaviour:
- Reset (synchronous, active-high; clk edge with reset=1): state IDLE. fire_req=0, fire_x=fire_y=0, abort=0, engage_count=0, confirm and timer counters 0. Applies mid-operation; fire_req drops on that edge.
- Accept: a sample is accepted when data_in_valid && data_in_ready.
- data_in_ready = 1 in all states except FIRE (0).
- Qualifying sample: target_found_in=1 and ZONE_X_MIN<=x_in<=ZONE_X_MAX and ZONE_Y_MIN<=y_in<=ZONE_Y_MAX. Unsigned compares, bounds inclusive.
- Every accepted qualifying sample in IDLE/TRACK/ARMED latches x_in/y_in into the coordinate register driving fire_x/fire_y.
- IDLE: accepted qualifying sample sets confirm=1.
  - Next state TRACK, or ARMED directly if CONFIRM_COUNT==1.
  - Non-qualifying samples are ignored.
- TRACK: accepted qualifying sample increments confirm.
  - When confirm+1==CONFIRM_COUNT: go to ARMED, clear arm timer.
  - Accepted non-qualifying sample: go to IDLE, confirm=0. No abort pulse.
- ARMED: arm timer increments every cycle.
  - Priority 1: accepted non-qualifying sample → IDLE, abort=1 for one cycle.
  - Priority 2: timer reaches ARM_TIMEOUT-1 → IDLE, abort=1.
  - Priority 3: arm_enable=1 → FIRE. fire_req rises the next cycle (1-cycle latency from arm_enable), using coordinates latched up to and including that cycle's sample.
  - Qualifying samples keep updating coordinates and do not reset the timer.
- FIRE: fire_req=1; fire_x/fire_y frozen; no samples accepted.
  - fire_ack=1 → COOLDOWN, fire_req=0 on the next cycle, engage_count+1 (saturating), cooldown timer cleared.
  - fire_ack arriving in the same cycle fire_req first rises is valid. fire_ack outside FIRE is ignored.
- COOLDOWN: samples accepted and discarded (no latch, no counting).
  - After COOLDOWN_CYCLES cycles → IDLE with confirm=0.
- abort is low in all cycles except the single abort cycle.

Test Plan:
- Defaults, 3 accepted samples (500,600,found=1), arm_enable held 1 → TRACK at 1st, ARMED after 3rd, fire_req=1 the cycle after ARMED entry with fire_x=500, fire_y=600; data_in_ready=0 in FIRE.
- In FIRE, drive fire_ack=1 once → fire_req=0 next cycle, engage_count=1, state COOLDOWN for 500 cycles, then IDLE; samples during COOLDOWN do not move state.
- TRACK with confirm=2, accept sample x=50 (out of zone) → IDLE, no abort, confirm reset; three fresh qualifying samples required to arm.
- ARMED, arm_enable=0 for 1000 cycles → abort pulse exactly one cycle, state IDLE; same cycle as arm_enable=1 with a target_found_in=0 sample → abort wins, no fire_req.
- Boundary: x=100,y=60000 qualifies; x=99 or y=60001 does not; CONFIRM_COUNT=1 build goes IDLE→ARMED on first qualifying sample.
- Assert reset during FIRE with fire_req=1 → next cycle fire_req=0, state IDLE, engage_count=0; 256 acknowledged shots leave engage_count=255.
